// File: rtl/rtc_pkg.sv
// Shared register-map offsets, CTRL/ACTRL bit positions and address decode
// classes for the rtc_alarm register window.
package rtc_pkg;

  localparam logic [23:0] CTRL_OFS     = 24'd0;
  localparam logic [23:0] TIMER_OFS    = 24'd1;
  localparam logic [23:0] SUBSEC_OFS   = 24'd7;
  localparam logic [23:0] ALARM_OFS    = 24'd8;
  localparam logic [23:0] ALARM_STRIDE = 24'd8;

  localparam int unsigned CTRL_EN    = 0;
  localparam int unsigned CTRL_CLEAR = 1;
  localparam int unsigned CTRL_SNAP  = 2;
  localparam int unsigned CTRL_OVF   = 7;

  localparam int unsigned ACTRL_ARM  = 0;
  localparam int unsigned ACTRL_PEND = 1;

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_CTRL,
    SEL_TIMER,
    SEL_SUBSEC,
    SEL_ALARM
  } reg_sel_e;

endpackage

// File: rtl/rtc_alarm_ch.sv
// One alarm compare channel: compare register, ARM/PEND bits, match on the
// timer-increment strobe and a one-cycle irq pulse.
module rtc_alarm_ch
  import rtc_pkg::*;
#(
  parameter int unsigned TIMER_BYTES = 3,
  localparam int unsigned TW = 8 * TIMER_BYTES
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [2:0]    ofs,
  input  logic [7:0]    wr_data,
  input  logic          inc,
  input  logic [TW-1:0] timer_new,
  output logic [7:0]    rd_data,
  output logic          irq
);

  logic [TW-1:0] cmp;
  logic          arm;
  logic          pend;
  logic          match;
  logic          actrl_wr;

  assign match    = inc && arm && (timer_new == cmp);
  assign actrl_wr = wr_en && (ofs == 3'd0);

  always_ff @(posedge clk) begin
    if (reset) begin
      cmp  <= '0;
      arm  <= 1'b0;
      pend <= 1'b0;
      irq  <= 1'b0;
    end else begin
      irq <= match;
      if (actrl_wr) arm <= wr_data[ACTRL_ARM];
      if (match) pend <= 1'b1;
      else if (actrl_wr && wr_data[ACTRL_PEND]) pend <= 1'b0;
      for (int unsigned k = 0; k < TIMER_BYTES; k++) begin
        if (wr_en && (ofs == 3'(k + 1))) cmp[8*k +: 8] <= wr_data;
      end
    end
  end

  always_comb begin
    rd_data = '0;
    if (ofs == 3'd0) begin
      rd_data[ACTRL_ARM]  = arm;
      rd_data[ACTRL_PEND] = pend;
    end
    for (int unsigned k = 0; k < TIMER_BYTES; k++) begin
      if (ofs == 3'(k + 1)) rd_data = cmp[8*k +: 8];
    end
  end

endmodule

// File: rtl/rtc_alarm.sv
// Prescaled real-time counter with snapshot, sticky overflow and alarm channels.
// Define RTC_SUBSECOND_READ_EN to expose the live prescaler MSBs at offset +7.
module rtc_alarm
  import rtc_pkg::*;
#(
  parameter int unsigned TIMER_BYTES   = 3,
  parameter int unsigned PRESCALE_BITS = 15,
  parameter int unsigned NUM_ALARMS    = 2,
  parameter logic [23:0] BASE_ADDR     = 24'h2008
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clk_ce,
  input  logic                  clk_rt_ce,
  input  logic                  bus_write,
  input  logic [23:0]           bus_address_in,
  input  logic [7:0]            bus_data_in,
  output logic [7:0]            bus_data_out,
  output logic [NUM_ALARMS-1:0] irq_alarm,
  output logic                  irq_overflow
);

  localparam int unsigned TW = 8 * TIMER_BYTES;

  logic                     en;
  logic                     ovf;
  logic [TW-1:0]            timer;
  logic [TW-1:0]            snapshot;
  logic [TW-1:0]            timer_next;
  logic [TW-1:0]            timer_loaded;
  logic [PRESCALE_BITS-1:0] prescale;

  logic [23:0] ofs;
  logic        in_win;
  reg_sel_e    sel;
  logic        wr, ctrl_wr, clear, snap, timer_wr, tick, inc, wrap;

  logic [NUM_ALARMS-1:0] ch_sel;
  logic [7:0]            ch_rd [NUM_ALARMS];

  assign ofs    = bus_address_in - BASE_ADDR;
  assign in_win = bus_address_in >= BASE_ADDR;

  always_comb begin
    sel = SEL_NONE;
    if (in_win) begin
      if (ofs == CTRL_OFS) sel = SEL_CTRL;
      else if (ofs >= TIMER_OFS && ofs < TIMER_OFS + 24'(TIMER_BYTES)) sel = SEL_TIMER;
      else if (ofs == SUBSEC_OFS) sel = SEL_SUBSEC;
      else if (ofs >= ALARM_OFS && ofs < ALARM_OFS + ALARM_STRIDE * 24'(NUM_ALARMS))
        sel = SEL_ALARM;
    end
  end

  assign wr       = clk_ce && bus_write;
  assign ctrl_wr  = wr && (sel == SEL_CTRL);
  assign clear    = ctrl_wr && bus_data_in[CTRL_CLEAR];
  assign snap     = ctrl_wr && bus_data_in[CTRL_SNAP];
  assign timer_wr = wr && (sel == SEL_TIMER);
  assign tick     = en && clk_rt_ce;
  // CLEAR and byte loads both suppress the carry, so alarms/overflow never see them
  assign inc      = tick && (&prescale) && !clear && !timer_wr;
  assign wrap     = inc && (&timer);

  assign timer_next = timer + TW'(1);

  always_comb begin
    timer_loaded = timer;
    for (int unsigned k = 0; k < TIMER_BYTES; k++) begin
      if (ofs == TIMER_OFS + 24'(k)) timer_loaded[8*k +: 8] = bus_data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      en           <= 1'b0;
      ovf          <= 1'b0;
      timer        <= '0;
      prescale     <= '0;
      snapshot     <= '0;
      irq_overflow <= 1'b0;
    end else begin
      irq_overflow <= wrap;
      if (ctrl_wr) en <= bus_data_in[CTRL_EN];
      if (wrap) ovf <= 1'b1;
      else if (ctrl_wr && bus_data_in[CTRL_OVF]) ovf <= 1'b0;
      if (clear) begin
        timer    <= '0;
        prescale <= '0;
        snapshot <= '0;
      end else begin
        if (tick) prescale <= prescale + PRESCALE_BITS'(1);
        if (timer_wr) timer <= timer_loaded;
        else if (inc) timer <= timer_next;
        if (snap) snapshot <= timer;
      end
    end
  end

  for (genvar a = 0; a < NUM_ALARMS; a++) begin : g_ch
    localparam logic [23:0] CH_BASE = ALARM_OFS + ALARM_STRIDE * 24'(a);

    assign ch_sel[a] = (sel == SEL_ALARM) && (ofs >= CH_BASE) && (ofs < CH_BASE + ALARM_STRIDE);

    rtc_alarm_ch #(
      .TIMER_BYTES(TIMER_BYTES)
    ) u_ch (
      .clk      (clk),
      .reset    (reset),
      .wr_en    (wr && ch_sel[a]),
      .ofs      (3'(ofs - CH_BASE)),
      .wr_data  (bus_data_in),
      .inc      (inc),
      .timer_new(timer_next),
      .rd_data  (ch_rd[a]),
      .irq      (irq_alarm[a])
    );
  end

  always_comb begin
    bus_data_out = '0;
    case (sel)
      SEL_CTRL: begin
        bus_data_out[CTRL_EN]  = en;
        bus_data_out[CTRL_OVF] = ovf;
      end
      SEL_TIMER: begin
        for (int unsigned k = 0; k < TIMER_BYTES; k++) begin
          if (ofs == TIMER_OFS + 24'(k)) bus_data_out = snapshot[8*k +: 8];
        end
      end
      SEL_SUBSEC: begin
`ifdef RTC_SUBSECOND_READ_EN
        bus_data_out = prescale[PRESCALE_BITS-1 -: 8];
`endif
      end
      SEL_ALARM: begin
        for (int unsigned a = 0; a < NUM_ALARMS; a++) begin
          if (ch_sel[a]) bus_data_out = ch_rd[a];
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_rtc_alarm.sv
// Scoreboard bench for rtc_alarm: a tick-count reference model predicts reads
// and irq pulses; a negedge monitor pops and compares.
module tb_rtc_alarm;

  localparam int unsigned TB = 3;
  localparam int unsigned P  = 8;
  localparam int unsigned NA = 2;
  localparam logic [23:0] BASE = 24'h2008;
  localparam int PER = 1 << P;

  localparam longint unsigned PMASK = (64'd1 << P) - 1;
  localparam longint unsigned VMASK = (64'd1 << (8 * TB + P)) - 1;

  localparam logic [23:0] A_CTRL = BASE;
  localparam logic [23:0] A_T0   = BASE + 24'd1;
  localparam logic [23:0] A_T1   = BASE + 24'd2;
  localparam logic [23:0] A_T2   = BASE + 24'd3;
  localparam logic [23:0] A_SUB  = BASE + 24'd7;
  localparam logic [23:0] A_AC0  = BASE + 24'd8;
  localparam logic [23:0] A_AC1  = BASE + 24'd16;

  logic clk = 1'b0;
  logic reset, clk_ce, clk_rt_ce, bus_write;
  logic [23:0] bus_address_in;
  logic [7:0] bus_data_in, bus_data_out;
  logic [NA-1:0] irq_alarm;
  logic irq_overflow;

  always #5 clk = ~clk;

  rtc_alarm #(
    .TIMER_BYTES(TB),
    .PRESCALE_BITS(P),
    .NUM_ALARMS(NA),
    .BASE_ADDR(BASE)
  ) dut (
    .clk(clk),
    .reset(reset),
    .clk_ce(clk_ce),
    .clk_rt_ce(clk_rt_ce),
    .bus_write(bus_write),
    .bus_address_in(bus_address_in),
    .bus_data_in(bus_data_in),
    .bus_data_out(bus_data_out),
    .irq_alarm(irq_alarm),
    .irq_overflow(irq_overflow)
  );

  typedef struct {
    string       name;
    logic [23:0] addr;
    logic [7:0]  want;
  } rd_exp_t;

  rd_exp_t    rd_q[$];
  logic [NA:0] irq_q[$];
  int checks = 0;
  int errors = 0;

  // Reference model: timer and prescaler viewed as one combined tick count.
  longint unsigned m_v    = 0;
  longint unsigned m_snap = 0;
  longint unsigned m_cmp[NA];
  logic            m_arm[NA];
  logic            m_pend[NA];
  logic            m_en  = 1'b0;
  logic            m_ovf = 1'b0;
  logic [NA:0]     m_irq;

  function automatic logic [7:0] model_read(input logic [23:0] addr);
    int ofs, a, lo;
    if (addr < BASE) return 8'h00;
    ofs = int'(addr - BASE);
    if (ofs == 0) return {m_ovf, 6'b0, m_en};
    if (ofs >= 1 && ofs <= TB) return 8'(m_snap >> (8 * (ofs - 1)));
`ifdef RTC_SUBSECOND_READ_EN
    if (ofs == 7) return 8'((m_v & PMASK) >> (P - 8));
`endif
    if (ofs >= 8 && ofs < 8 + 8 * NA) begin
      a  = (ofs - 8) / 8;
      lo = (ofs - 8) % 8;
      if (lo == 0) return {6'b0, m_pend[a], m_arm[a]};
      if (lo <= TB) return 8'(m_cmp[a] >> (8 * (lo - 1)));
    end
    return 8'h00;
  endfunction

  task automatic model_step(input logic rst, input logic ce, input logic rt, input logic wr,
                            input logic [23:0] addr, input logic [7:0] d);
    longint unsigned t, t_new, pre;
    int ofs, lo;
    bit w, ctrl, clr, twr, incd;
    m_irq = '0;
    if (rst) begin
      m_v = 0; m_snap = 0; m_en = 0; m_ovf = 0;
      for (int a = 0; a < NA; a++) begin
        m_cmp[a] = 0; m_arm[a] = 0; m_pend[a] = 0;
      end
      return;
    end
    w    = ce && wr;
    ofs  = (addr >= BASE) ? int'(addr - BASE) : -1;
    t    = m_v >> P;
    pre  = m_v & PMASK;
    ctrl = w && (ofs == 0);
    clr  = ctrl && d[1];
    twr  = w && (ofs >= 1) && (ofs <= TB);
    incd = 0;
    if (ctrl && d[2] && !clr) m_snap = t;
    if (clr) begin
      m_v = 0;
      m_snap = 0;
    end else if (twr) begin
      t_new = (t & ~(64'hFF << (8 * (ofs - 1)))) | (longint'(d) << (8 * (ofs - 1)));
      if (m_en && rt) pre = (pre + 1) & PMASK;
      m_v = (t_new << P) | pre;
    end else if (m_en && rt) begin
      m_v  = (m_v + 1) & VMASK;
      incd = ((m_v >> P) != t);
    end
    if (incd) begin
      t_new = m_v >> P;
      if (t_new == 0) m_irq[NA] = 1'b1;
      for (int a = 0; a < NA; a++) if (m_arm[a] && m_cmp[a] == t_new) m_irq[a] = 1'b1;
    end
    if (ctrl) m_en = d[0];
    if (m_irq[NA]) m_ovf = 1'b1;
    else if (ctrl && d[7]) m_ovf = 1'b0;
    for (int a = 0; a < NA; a++) begin
      lo = -1;
      if (w && ofs >= 8 + 8 * a && ofs < 16 + 8 * a) lo = ofs - 8 - 8 * a;
      if (lo == 0) m_arm[a] = d[0];
      if (m_irq[a]) m_pend[a] = 1'b1;
      else if (lo == 0 && d[1]) m_pend[a] = 1'b0;
      if (lo >= 1 && lo <= TB)
        m_cmp[a] = (m_cmp[a] & ~(64'hFF << (8 * (lo - 1)))) | (longint'(d) << (8 * (lo - 1)));
    end
  endtask

  // want < 0 takes the expected read value from the model
  task automatic cyc(input logic rst, input logic ce, input logic rt, input logic wr,
                     input logic [23:0] addr, input logic [7:0] d,
                     input bit rd, input string nm, input int want);
    rd_exp_t     e;
    logic [NA:0] nxt;
    reset = rst; clk_ce = ce; clk_rt_ce = rt; bus_write = wr;
    bus_address_in = addr; bus_data_in = d;
    if (rd) begin
      e.name = nm;
      e.addr = addr;
      e.want = (want >= 0) ? 8'(want) : model_read(addr);
      rd_q.push_back(e);
    end
    model_step(rst, ce, rt, wr, addr, d);
    nxt = m_irq;
    @(posedge clk);
    #1;
    irq_q.push_back(nxt);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b1, 1'b1, 1'b0, 24'h0, 8'h00, 1'b0, "", 0);
  endtask

  task automatic wr_reg(input logic [23:0] addr, input logic [7:0] d);
    cyc(1'b0, 1'b1, 1'b0, 1'b1, addr, d, 1'b0, "", 0);
  endtask

  task automatic rd_reg(input string nm, input logic [23:0] addr, input int want);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, addr, 8'h00, 1'b1, nm, want);
  endtask

  rd_exp_t     mon_r;
  logic [NA:0] mon_e;

  always @(negedge clk) begin
    if (irq_q.size() > 0) begin
      mon_e = irq_q.pop_front();
      checks++;
      if ({irq_overflow, irq_alarm} !== mon_e) begin
        errors++;
        $display("FAIL irq {ovf,alarm} got %b want %b at %0t", {irq_overflow, irq_alarm}, mon_e, $time);
      end
    end
    if (rd_q.size() > 0) begin
      mon_r = rd_q.pop_front();
      checks++;
      if (bus_data_out !== mon_r.want) begin
        errors++;
        $display("FAIL %s addr %h got %h want %h at %0t", mon_r.name, mon_r.addr, bus_data_out, mon_r.want, $time);
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]      d;
    logic [23:0]     addr;
    longint unsigned tv;
    int              r, a, lo;
    bit              ce, rt;

    repeat (3) cyc(1'b1, 1'b0, 1'b0, 1'b0, 24'h0, 8'h00, 1'b0, "", 0);

    // reset state
    rd_reg("rst_ctrl", A_CTRL, 8'h00);
    rd_reg("rst_t0", A_T0, 8'h00);
    rd_reg("rst_t1", A_T1, 8'h00);
    rd_reg("rst_t2", A_T2, 8'h00);
    rd_reg("rst_ac0", A_AC0, 8'h00);
    rd_reg("rst_ac1", A_AC1, 8'h00);
    rd_reg("rst_sub", A_SUB, 8'h00);
    rd_reg("below_base", BASE - 24'd1, 8'h00);

    // one prescale period -> timer 1; write without clk_ce ignored
    wr_reg(A_CTRL, 8'h01);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, A_CTRL, 8'h00, 1'b0, "", 0);
    rd_reg("ce_gated_wr", A_CTRL, 8'h01);
    ticks(PER);
    wr_reg(A_CTRL, 8'h05);
    rd_reg("per_t0", A_T0, 8'h01);
    rd_reg("per_t1", A_T1, 8'h00);
    rd_reg("per_t2", A_T2, 8'h00);
    rd_reg("per_ctrl", A_CTRL, 8'h01);

    // wrap from all-ones
    wr_reg(A_T0, 8'hFF);
    wr_reg(A_T1, 8'hFF);
    wr_reg(A_T2, 8'hFF);
    ticks(PER);
    wr_reg(A_CTRL, 8'h05);
    rd_reg("wrap_t0", A_T0, 8'h00);
    rd_reg("wrap_t1", A_T1, 8'h00);
    rd_reg("wrap_t2", A_T2, 8'h00);
    rd_reg("wrap_ovf", A_CTRL, 8'h81);
    wr_reg(A_CTRL, 8'h81);
    rd_reg("ovf_w1c", A_CTRL, 8'h01);

    // alarm0 at 5, counting from 0
    wr_reg(A_AC0 + 24'd1, 8'h05);
    wr_reg(A_AC0 + 24'd2, 8'h00);
    wr_reg(A_AC0 + 24'd3, 8'h00);
    wr_reg(A_AC0, 8'h01);
    wr_reg(A_CTRL, 8'h03);
    ticks(5 * PER);
    rd_reg("alm_pend", A_AC0, 8'h03);
    rd_reg("alm_cmp0", A_AC0 + 24'd1, 8'h05);
    wr_reg(A_AC0, 8'h03);
    rd_reg("alm_w1c", A_AC0, 8'h01);
    wr_reg(A_T0, 8'h07);
    wr_reg(A_T0, 8'h05);
    rd_reg("alm_load_nomatch", A_AC0, 8'h01);

    // SNAP coincident with 00FFFF -> 010000
    wr_reg(A_CTRL, 8'h03);
    wr_reg(A_T0, 8'hFF);
    wr_reg(A_T1, 8'hFF);
    ticks(PER - 1);
    cyc(1'b0, 1'b1, 1'b1, 1'b1, A_CTRL, 8'h05, 1'b0, "", 0);
    rd_reg("snapinc_t0", A_T0, 8'hFF);
    rd_reg("snapinc_t1", A_T1, 8'hFF);
    rd_reg("snapinc_t2", A_T2, 8'h00);
    wr_reg(A_CTRL, 8'h05);
    rd_reg("snap2_t0", A_T0, 8'h00);
    rd_reg("snap2_t1", A_T1, 8'h00);
    rd_reg("snap2_t2", A_T2, 8'h01);

    // CLEAR coincident with increment and alarm1 match
    wr_reg(A_AC1 + 24'd1, 8'h01);
    wr_reg(A_AC1 + 24'd2, 8'h00);
    wr_reg(A_AC1 + 24'd3, 8'h01);
    wr_reg(A_AC1, 8'h01);
    ticks(PER - 1);
    cyc(1'b0, 1'b1, 1'b1, 1'b1, A_CTRL, 8'h03, 1'b0, "", 0);
    wr_reg(A_CTRL, 8'h05);
    rd_reg("clr_t0", A_T0, 8'h00);
    rd_reg("clr_t2", A_T2, 8'h00);
    rd_reg("clr_ac1", A_AC1, 8'h01);
    rd_reg("clr_sub", A_SUB, 8'h00);
    ticks(PER - 1);
    wr_reg(A_CTRL, 8'h05);
    rd_reg("clr_pre_t0", A_T0, 8'h00);
    ticks(1);
    wr_reg(A_CTRL, 8'h05);
    rd_reg("clr_pre_t0b", A_T0, 8'h01);

    // sub-second read at half period
    wr_reg(A_CTRL, 8'h03);
    ticks(PER / 2);
`ifdef RTC_SUBSECOND_READ_EN
    rd_reg("subsec", A_SUB, 8'h80);
`else
    rd_reg("subsec", A_SUB, 8'h00);
`endif
    wr_reg(A_SUB, 8'h55);
    rd_reg("subsec_ctrl", A_CTRL, 8'h01);

    // randomized traffic against the model
    for (int i = 0; i < 9000; i++) begin
      r  = $urandom_range(0, 99);
      ce = ($urandom_range(0, 7) != 0);
      rt = ($urandom_range(0, 3) != 0);
      d  = 8'($urandom);
      if (r < 72) begin
        cyc(1'b0, ce, rt, 1'b0, 24'h0, d, 1'b0, "", 0);
      end else if (r < 84) begin
        addr = BASE - 24'd2 + 24'($urandom_range(0, 8 + 8 * NA + 4));
        cyc(1'b0, ce, rt, 1'b0, addr, 8'h00, 1'b1, "rand_rd", -1);
      end else if (r < 88) begin
        d[0] = ($urandom_range(0, 7) != 0);
        d[1] = ($urandom_range(0, 15) == 0);
        cyc(1'b0, ce, rt, 1'b1, A_CTRL, d, 1'b0, "", 0);
      end else if (r < 90) begin
        addr = A_T0 + 24'($urandom_range(0, TB - 1));
        cyc(1'b0, ce, rt, 1'b1, addr, d, 1'b0, "", 0);
      end else if (r < 97) begin
        a  = $urandom_range(0, NA - 1);
        lo = $urandom_range(0, 1);
        addr = A_AC0 + 24'(8 * a);
        if (lo == 0) begin
          cyc(1'b0, ce, rt, 1'b1, addr, d, 1'b0, "", 0);
        end else begin
          tv = (m_v >> P) + longint'($urandom_range(0, 2));
          for (int k = 0; k < TB; k++)
            cyc(1'b0, 1'b1, rt, 1'b1, addr + 24'(k + 1), 8'(tv >> (8 * k)), 1'b0, "", 0);
        end
      end else begin
        case ($urandom_range(0, 4))
          0: addr = BASE + 24'd4;
          1: addr = BASE + 24'd6;
          2: addr = A_SUB;
          3: addr = A_AC0 + 24'd5;
          default: addr = BASE + 24'(8 + 8 * NA);
        endcase
        cyc(1'b0, ce, rt, 1'b1, addr, d, 1'b0, "", 0);
        cyc(1'b0, 1'b1, rt, 1'b0, addr, 8'h00, 1'b1, "unmapped_rd", -1);
      end
    end

    cyc(1'b0, 1'b1, 1'b0, 1'b0, 24'h0, 8'h00, 1'b0, "", 0);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (irq_q.size() != 0 || rd_q.size() != 0) begin
      errors++;
      $display("FAIL drain irq_q %0d rd_q %0d want 0 0", irq_q.size(), rd_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
